// File: rtl/lm32_itlb_walker_pkg.sv
// Shared definitions for the ITLB hardware page-table walker:
// PTE field positions, fault cause codes and walker FSM states.
package lm32_itlb_walker_pkg;

    localparam int unsigned PTE_V_BIT   = 0;
    localparam int unsigned PTE_U_BIT   = 1;
    localparam int unsigned PTE_X_BIT   = 2;
    localparam int unsigned PTE_PFN_MSB = 31;
    localparam int unsigned PTE_PFN_LSB = 12;
    localparam int unsigned PFN_W       = PTE_PFN_MSB - PTE_PFN_LSB + 1;

    typedef enum logic [2:0] {
        CAUSE_NONE        = 3'd0,
        CAUSE_L1_INVALID  = 3'd1,
        CAUSE_L2_INVALID  = 3'd2,
        CAUSE_NO_EXEC     = 3'd3,
        CAUSE_USER_DENIED = 3'd4,
        CAUSE_BUS         = 3'd5
    } fault_cause_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1_REQ,
        ST_L1_GAP,
        ST_L2_REQ,
        ST_DONE
    } walk_state_e;

    function automatic logic [PFN_W-1:0] pte_pfn(input logic [31:0] pte);
        return pte[PTE_PFN_MSB:PTE_PFN_LSB];
    endfunction

endpackage

// File: rtl/lm32_itlb_walker_if.sv
// Wishbone classic read-only bus between the ITLB walker (master) and memory.
interface lm32_itlb_walker_if;

    logic [31:0] adr;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        ack;
    logic        err;

    modport master (output adr, cyc, stb, we, sel, input dat, ack, err);
    modport slave  (input adr, cyc, stb, we, sel, output dat, ack, err);

endinterface

// File: rtl/lm32_itlb_walker.sv
// Two-level page-table walker refilling the instruction TLB on a miss.
// Produces a one-cycle update strobe on success or a fault strobe with cause.
module lm32_itlb_walker
    import lm32_itlb_walker_pkg::*;
#(
    parameter int unsigned page_size      = 4096,
    parameter int unsigned l1_index_width = 10,
    parameter int unsigned l2_index_width = 10,
    parameter int unsigned bus_timeout    = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        miss_i,
    input  logic [31:0] miss_vaddr_i,
    input  logic        kernel_mode_i,
    input  logic [31:0] ptbr_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        upd_valid_o,
    output logic [31:0] upd_vaddr_o,
    output logic [31:0] upd_paddr_o,
    output logic        fault_o,
    output logic [2:0]  fault_cause_o,
    lm32_itlb_walker_if.master wb
);

    localparam int unsigned TMO_W = $clog2(bus_timeout + 1);

    if (page_size != 4096 || l1_index_width + l2_index_width != 20 || bus_timeout == 0) begin : g_bad_cfg
        $error("lm32_itlb_walker: only 4 KiB pages with a 10/10 index split and nonzero timeout are supported");
    end

    walk_state_e        state_q, state_d;
    logic [PFN_W-1:0]   va_q, va_d;
    logic               kernel_q, kernel_d;
    logic [PFN_W-1:0]   l1_base_q, l1_base_d;
    logic [31:0]        adr_q, adr_d;
    logic               req_q, req_d;
    logic               abort_q, abort_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               busy_q, busy_d;
    logic               upd_valid_q, upd_valid_d;
    logic [PFN_W-1:0]   upd_vpn_q, upd_vpn_d;
    logic [PFN_W-1:0]   upd_ppn_q, upd_ppn_d;
    logic               fault_q, fault_d;
    fault_cause_e       cause_q, cause_d;
    fault_cause_e       flt_code;
    logic               timeout;
    logic               aborting;
    logic               unused_bits;

    assign timeout  = req_q && !wb.ack && !wb.err && (tmo_q == TMO_W'(bus_timeout - 1));
    assign aborting = abort_q || abort_i;

    always_comb begin
        state_d     = state_q;
        va_d        = va_q;
        kernel_d    = kernel_q;
        l1_base_d   = l1_base_q;
        adr_d       = adr_q;
        req_d       = req_q;
        abort_d     = abort_q;
        tmo_d       = tmo_q;
        upd_valid_d = 1'b0;
        upd_vpn_d   = upd_vpn_q;
        upd_ppn_d   = upd_ppn_q;
        fault_d     = 1'b0;
        cause_d     = cause_q;
        flt_code    = CAUSE_NONE;

        unique case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (miss_i && !abort_i) begin
                    va_d     = miss_vaddr_i[31:12];
                    kernel_d = kernel_mode_i;
                    adr_d    = {ptbr_i[31:12], miss_vaddr_i[31 -: l1_index_width], 2'b00};
                    req_d    = 1'b1;
                    tmo_d    = '0;
                    state_d  = ST_L1_REQ;
                end
            end
            ST_L1_REQ, ST_L2_REQ: begin
                if (abort_i) abort_d = 1'b1;
                // err outranks a coincident ack; an aborted walk still waits out its bus cycle
                if (wb.err || timeout) begin
                    req_d = 1'b0;
                    if (aborting) state_d = ST_IDLE;
                    else          flt_code = CAUSE_BUS;
                end else if (wb.ack) begin
                    req_d = 1'b0;
                    if (aborting) begin
                        state_d = ST_IDLE;
                    end else if (state_q == ST_L1_REQ) begin
                        if (!wb.dat[PTE_V_BIT]) begin
                            flt_code = CAUSE_L1_INVALID;
                        end else begin
                            l1_base_d = pte_pfn(wb.dat);
                            state_d   = ST_L1_GAP;
                        end
                    end else begin
                        if (!wb.dat[PTE_V_BIT])                     flt_code = CAUSE_L2_INVALID;
                        else if (!wb.dat[PTE_X_BIT])                flt_code = CAUSE_NO_EXEC;
                        else if (!kernel_q && !wb.dat[PTE_U_BIT])   flt_code = CAUSE_USER_DENIED;
                        else begin
                            upd_valid_d = 1'b1;
                            upd_vpn_d   = va_q;
                            upd_ppn_d   = pte_pfn(wb.dat);
                            state_d     = ST_DONE;
                        end
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_L1_GAP: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    adr_d   = {l1_base_q, va_q[l2_index_width-1:0], 2'b00};
                    req_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_L2_REQ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Faults reuse DONE as their single strobe cycle
        if (flt_code != CAUSE_NONE) begin
            fault_d = 1'b1;
            cause_d = flt_code;
            state_d = ST_DONE;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            va_q        <= '0;
            kernel_q    <= 1'b0;
            l1_base_q   <= '0;
            adr_q       <= '0;
            req_q       <= 1'b0;
            abort_q     <= 1'b0;
            tmo_q       <= '0;
            busy_q      <= 1'b0;
            upd_valid_q <= 1'b0;
            upd_vpn_q   <= '0;
            upd_ppn_q   <= '0;
            fault_q     <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            va_q        <= va_d;
            kernel_q    <= kernel_d;
            l1_base_q   <= l1_base_d;
            adr_q       <= adr_d;
            req_q       <= req_d;
            abort_q     <= abort_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
            upd_valid_q <= upd_valid_d;
            upd_vpn_q   <= upd_vpn_d;
            upd_ppn_q   <= upd_ppn_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
        end
    end

    assign busy_o        = busy_q;
    assign upd_valid_o   = upd_valid_q;
    assign upd_vaddr_o   = {upd_vpn_q, 12'h000};
    assign upd_paddr_o   = {upd_ppn_q, 12'h000};
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;

    assign wb.adr = adr_q;
    assign wb.cyc = req_q;
    assign wb.stb = req_q;
    assign wb.we  = 1'b0;
    assign wb.sel = 4'hF;

    assign unused_bits = ^{ptbr_i[11:0], miss_vaddr_i[11:0], wb.dat[11:3]};

endmodule

// File: doc/lm32_itlb_walker.md
Name: lm32_itlb_walker

Overview:
- Hardware page-table walker feeding the instruction TLB refill path.
- On an ITLB miss it walks a two-level page table in memory over a Wishbone classic read-only master port.
- On success it returns a one-cycle update (virtual page, physical page) for the ITLB to write. On failure it returns a fault code for the exception logic.
- It removes the software refill round-trip for instruction misses. It sits between the fetch-stage miss signal and the ITLB update inputs.

Parameters:
- page_size, 4096, page size in bytes; only 4096 is supported, and any other value is an elaboration error.
- l1_index_width, 10, VA[31:22] indexes the L1 table.
- l2_index_width, 10, VA[21:12] indexes the L2 table.
- bus_timeout, 255, number of cycles stb may stay unacknowledged before a bus fault.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- miss_i  in  1  ITLB miss request; sampled only in IDLE
- miss_vaddr_i  in  32  faulting virtual byte address
- kernel_mode_i  in  1  privilege level, sampled with miss_i
- ptbr_i  in  32  L1 table base; bits [11:0] are ignored
- abort_i  in  1  cancels any walk (flush or exception)
- busy_o  out  1  walk in progress
- upd_valid_o  out  1  single-cycle ITLB update strobe
- upd_vaddr_o  out  32  {VA[31:12], 12'b0}
- upd_paddr_o  out  32  {PFN, 12'b0}
- fault_o  out  1  single-cycle walk-fault strobe
- fault_cause_o  out  3  1 = L1 invalid, 2 = L2 invalid, 3 = no exec, 4 = user denied, 5 = bus error/timeout
- wb_adr_o  out  32  PTE address
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  tied 0
- wb_sel_o  out  4  tied 4'hF
- wb_dat_i  in  32  PTE data
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset is asynchronous, so it aborts any bus cycle immediately and cyc/stb drop.
- PTE format:
  - bit0 V (valid)
  - bit1 U (user accessible)
  - bit2 X (executable)
  - [31:12] PFN, or the L2 table base in an L1 entry.
- FSM states: IDLE, L1_REQ, L1_GAP, L2_REQ, DONE.
- IDLE:
  - If miss_i && !abort_i: latch vaddr and kernel_mode, set busy_o, go to L1_REQ.
  - In the same cycle, register wb_adr_o = {ptbr_i[31:12], VA[31:22], 2'b00} and cyc = stb = 1.
- L1_REQ:
  - Hold cyc/stb/adr until ack or err. Deassert cyc/stb on the edge that samples ack or err.
  - ack with V = 1: latch wb_dat_i[31:12] and go to L1_GAP.
  - ack with V = 0: fault, cause 1.
  - err: fault, cause 5.
- L1_GAP: one idle bus cycle. Register adr = {l1_pte[31:12], VA[21:12], 2'b00}, assert cyc/stb, go to L2_REQ.
- L2_REQ: ack/err handling as in L1_REQ, then check the entry:
  - V = 0: cause 2.
  - X = 0: cause 3.
  - !kernel && U = 0: cause 4.
  - Otherwise latch the PFN and go to DONE.
- DONE: upd_valid_o = 1 for exactly one cycle, upd_vaddr_o/upd_paddr_o valid that cycle, then go to IDLE.
- Fault path: fault_o = 1 for one cycle with fault_cause_o, then go to IDLE.
- Strobe outputs: upd_valid_o and fault_o are never high together. Data outputs hold their last value between strobes.
- Latency with zero-wait-state ack:
  - miss sampled at edge 0
  - L1 stb in cycle 1
  - gap in cycle 2
  - L2 stb in cycle 3
  - upd_valid_o in cycle 4
  - busy_o high cycles 1–4, low in cycle 5.
- Timeout:
  - A counter clears at each stb assertion and increments while stb && !ack && !err.
  - When it reaches bus_timeout: drop cyc/stb, fault cause 5.
  - Counter width is clog2(bus_timeout+1); it must not wrap.
- Abort:
  - In IDLE, abort_i wins over a coincident miss_i and no walk starts.
  - During L1_GAP or DONE: return to IDLE next edge with no strobe.
  - During L1_REQ or L2_REQ: set an abort flag and keep the bus cycle until ack/err/timeout, then return to IDLE with no upd and no fault strobe.
- miss_i while busy_o is ignored and is not queued.
- A simultaneous ack and err is treated as err.

Decomposition:
- Shared package/include (lm32_include.v style defines):
  - PTE bit positions (V, U, X, PFN range)
  - fault cause codes 1–5
  - FSM state encodings
- No sub-module. The timeout counter and the address mux are inline.

Test Plan:
- Happy path, zero-wait memory:
  - Setup: ptbr = 0x0010_0000, miss_vaddr = 0x4030_2ABC, kernel = 1; mem[0x0010_0400] = 0x0020_0001; mem[0x0020_0C08] = 0x0ABC_D005.
  - Required: L1 adr 0x0010_0400 in cycle 1, L2 adr 0x0020_0C08 in cycle 3, upd_valid_o in cycle 4 with vaddr 0x4030_2000 and paddr 0x0ABC_D000.
- Invalid L1 (mem[0x0010_0400] = 0):
  - fault_o pulse with cause 1, exactly one bus cycle, no upd.
- User permission (same tables, kernel = 0, L2 PTE 0x0ABC_D005 so U = 0):
  - fault cause 4.
  - With L2 PTE 0x0ABC_D007: upd succeeds.
  - With L2 PTE 0x0ABC_D003 (X = 0): cause 3.
- Wait states, timeout and error:
  - ack after 5 cycles: walk completes and upd_valid_o is delayed by 5.
  - ack withheld (bus_timeout = 255): cyc drops after 255 stb cycles with cause 5.
  - wb_err_i on the L2 access: cause 5.
- Abort:
  - abort_i in cycle 1 with ack in cycle 3: cyc is held until cycle 3, then IDLE with no upd and no fault.
  - abort_i coincident with miss_i in IDLE: busy_o stays 0.
- Reset mid-walk: assert rst_i asynchronously during L2_REQ → cyc, stb, busy_o and all strobes go to 0 without waiting for a clock edge; a new miss after release walks normally.
